rfphoenix_mc_fifo: RTL and testbench

//  Multi-channel FIFO: NCH independent queues (one per hardware thread) in one shared distributed RAM.
//  One write port and one read port, each selecting a channel per cycle.

---
 rtl/rfphoenix_mc_fifo_pkg.sv | 13 +
 rtl/rfphoenix_mcfifo_chan.sv | 73 +++++++
 rtl/rfphoenix_mc_fifo.sv | 105 ++++++++++
 tb/tb_rfphoenix_mc_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfphoenix_mc_fifo_pkg.sv
// Shared rfPhoenix types and constants for the multi-channel FIFO.
// Optional RFPHOENIX_MCFIFO_ERR_EN adds sticky ovf/unf flags in the FIFO.
package rfPhoenixPkg;

  localparam int MCFIFO_AFM_DEF = 4;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
  } mcfifo_stat_t;

endpackage

// File: rtl/rfphoenix_mcfifo_chan.sv
// Per-channel pointer pair, occupancy and status for rfphoenix_mc_fifo.
// RFPHOENIX_MCFIFO_ERR_EN adds sticky overflow/underflow flags.
module rfphoenix_mcfifo_chan
  import rfPhoenixPkg::*;
#(
  parameter int DEP = 16,
  parameter int AFM = MCFIFO_AFM_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_req,
  input  logic                   rd_req,
  output logic                   wr_ok,
  output logic                   rd_ok,
  output logic [$clog2(DEP)-1:0] widx,
  output logic [$clog2(DEP)-1:0] ridx,
  output logic [$clog2(DEP):0]   cnt,
  output mcfifo_stat_t           stat
`ifdef RFPHOENIX_MCFIFO_ERR_EN
  ,
  output logic                   ovf,
  output logic                   unf
`endif
);

  localparam int AW = $clog2(DEP);
  localparam int CW = AW + 1;

  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;

  assign cnt  = wptr - rptr;
  assign widx = wptr[AW-1:0];
  assign ridx = rptr[AW-1:0];

  assign stat.empty       = (cnt == '0);
  assign stat.full        = (cnt == CW'(DEP));
  assign stat.almost_full = (cnt >= CW'(DEP - AFM));

  // A same-cycle read frees the slot of a full channel; a
  // same-cycle write feeds the read of an empty one (bypass).
  assign wr_ok = wr_req & ~flush & (~stat.full | rd_req);
  assign rd_ok = rd_req & ~flush & (~stat.empty | wr_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

`ifdef RFPHOENIX_MCFIFO_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (flush) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wr_req & ~wr_ok) ovf <= 1'b1;
      if (rd_req & ~rd_ok) unf <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/rfphoenix_mc_fifo.sv
// Multi-channel FIFO: NCH queues of DEP words in one shared RAM.
// Define RFPHOENIX_MCFIFO_ERR_EN to expose sticky ovf/unf per channel.
module rfphoenix_mc_fifo
  import rfPhoenixPkg::*;
#(
  parameter int WID = 32,
  parameter int DEP = 16,
  parameter int NCH = 4,
  parameter int AFM = MCFIFO_AFM_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NCH-1:0]                    flush,
  input  logic                              wr,
  input  logic [$clog2(NCH)-1:0]            wr_ch,
  input  logic [WID-1:0]                    di,
  input  logic                              rd,
  input  logic [$clog2(NCH)-1:0]            rd_ch,
  output logic [WID-1:0]                    dout,
  output logic                              dout_v,
  output logic [$clog2(NCH)-1:0]            dout_ch,
  output logic [NCH-1:0][$clog2(DEP):0]     cnt,
  output logic [NCH-1:0]                    empty,
  output logic [NCH-1:0]                    full,
  output logic [NCH-1:0]                    almost_full
`ifdef RFPHOENIX_MCFIFO_ERR_EN
  ,
  output logic [NCH-1:0]                    ovf,
  output logic [NCH-1:0]                    unf
`endif
);

  localparam int AW  = $clog2(DEP);
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0]         wr_req;
  logic [NCH-1:0]         rd_req;
  logic [NCH-1:0]         wr_ok;
  logic [NCH-1:0]         rd_ok;
  logic [NCH-1:0][AW-1:0] widx;
  logic [NCH-1:0][AW-1:0] ridx;
  mcfifo_stat_t           stat [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign wr_req[c] = wr & (wr_ch == CHW'(c));
    assign rd_req[c] = rd & (rd_ch == CHW'(c));

    rfphoenix_mcfifo_chan #(
      .DEP (DEP),
      .AFM (AFM)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush[c]),
      .wr_req (wr_req[c]),
      .rd_req (rd_req[c]),
      .wr_ok  (wr_ok[c]),
      .rd_ok  (rd_ok[c]),
      .widx   (widx[c]),
      .ridx   (ridx[c]),
      .cnt    (cnt[c]),
      .stat   (stat[c])
`ifdef RFPHOENIX_MCFIFO_ERR_EN
      ,
      .ovf    (ovf[c]),
      .unf    (unf[c])
`endif
    );

    assign empty[c]       = stat[c].empty;
    assign full[c]        = stat[c].full;
    assign almost_full[c] = stat[c].almost_full;
  end

  logic [WID-1:0]        mem [NCH*DEP];
  logic [CHW+AW-1:0]     waddr;
  logic [CHW+AW-1:0]     raddr;
  logic                  pop;
  logic                  byp;

  assign waddr = {wr_ch, widx[wr_ch]};
  assign raddr = {rd_ch, ridx[rd_ch]};
  assign pop   = rd_ok[rd_ch];
  assign byp   = wr & (wr_ch == rd_ch) & empty[rd_ch];

  // Storage is deliberately not reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok[wr_ch]) mem[waddr] <= di;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout    <= '0;
      dout_v  <= 1'b0;
      dout_ch <= '0;
    end else begin
      dout_v <= pop;
      if (pop) begin
        dout    <= byp ? di : mem[raddr];
        dout_ch <= rd_ch;
      end
    end
  end

endmodule

// File: tb/tb_rfphoenix_mc_fifo.sv
// Self-checking bench for rfphoenix_mc_fifo against a queue model.
// Honours RFPHOENIX_MCFIFO_ERR_EN when defined.
module tb_rfphoenix_mc_fifo;

  localparam int WID = 32;
  localparam int DEP = 16;
  localparam int NCH = 4;

  logic            clk = 0;
  logic            rst;
  logic [NCH-1:0]  flush;
  logic            wr;
  logic [1:0]      wr_ch;
  logic [WID-1:0]  di;
  logic            rd;
  logic [1:0]      rd_ch;
  logic [WID-1:0]  dout;
  logic            dout_v;
  logic [1:0]      dout_ch;
  logic [NCH-1:0][4:0] cnt;
  logic [NCH-1:0]  empty;
  logic [NCH-1:0]  full;
  logic [NCH-1:0]  almost_full;
`ifdef RFPHOENIX_MCFIFO_ERR_EN
  logic [NCH-1:0]  ovf;
  logic [NCH-1:0]  unf;
`endif

  rfphoenix_mc_fifo #(
    .WID (WID),
    .DEP (DEP),
    .NCH (NCH),
    .AFM (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr          (wr),
    .wr_ch       (wr_ch),
    .di          (di),
    .rd          (rd),
    .rd_ch       (rd_ch),
    .dout        (dout),
    .dout_v      (dout_v),
    .dout_ch     (dout_ch),
    .cnt         (cnt),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full)
`ifdef RFPHOENIX_MCFIFO_ERR_EN
    ,
    .ovf         (ovf),
    .unf         (unf)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit [31:0] q [NCH][$];
  bit        e_v;
  bit [31:0] e_dout;
  bit [1:0]  e_ch;
  bit [NCH-1:0] e_ovf;
  bit [NCH-1:0] e_unf;

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t act=%0h exp=%0h", nm, idx, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) q[c].delete();
    e_v = 0;
    e_dout = 0;
    e_ch = 0;
    e_ovf = 0;
    e_unf = 0;
  endtask

  task automatic check_all();
    chk("dout_v", 0, 32'(dout_v), 32'(e_v));
    chk("dout", 0, dout, e_dout);
    chk("dout_ch", 0, 32'(dout_ch), 32'(e_ch));
    for (int c = 0; c < NCH; c++) begin
      int n;
      n = q[c].size();
      chk("cnt", c, 32'(cnt[c]), 32'(n));
      chk("empty", c, 32'(empty[c]), 32'(n == 0));
      chk("full", c, 32'(full[c]), 32'(n == DEP));
      chk("almost_full", c, 32'(almost_full[c]), 32'(n >= DEP - 4));
`ifdef RFPHOENIX_MCFIFO_ERR_EN
      chk("ovf", c, 32'(ovf[c]), 32'(e_ovf[c]));
      chk("unf", c, 32'(unf[c]), 32'(e_unf[c]));
`endif
    end
  endtask

  task automatic cyc(input bit w, input bit [1:0] wc, input bit [31:0] d,
                     input bit r, input bit [1:0] rc, input bit [3:0] fl);
    bit rok, wok, byp;
    int sr, sw;
    wr = w; wr_ch = wc; di = d; rd = r; rd_ch = rc; flush = fl;
    sr  = q[rc].size();
    sw  = q[wc].size();
    rok = r && !fl[rc] && (sr > 0 || (w && wc == rc));
    wok = w && !fl[wc] && (sw < DEP || (r && rc == wc));
    byp = rok && sr == 0;
    if (w && !fl[wc] && !wok) e_ovf[wc] = 1;
    if (r && !fl[rc] && !rok) e_unf[rc] = 1;
    for (int c = 0; c < NCH; c++)
      if (fl[c]) begin
        q[c].delete();
        e_ovf[c] = 0;
        e_unf[c] = 0;
      end
    e_v = rok;
    if (rok) begin
      e_ch = rc;
      if (byp) e_dout = d;
      else e_dout = q[rc].pop_front();
    end
    if (wok && !byp) q[wc].push_back(d);
    @(posedge clk);
    #1;
    wr = 0; rd = 0; flush = 0;
    check_all();
  endtask

  typedef struct {
    bit        w;
    bit [1:0]  wc;
    bit [31:0] d;
    bit        r;
    bit [1:0]  rc;
    bit        v;
    bit [31:0] dout;
    bit [4:0]  c1;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 1, 32'hA0, 0, 0, 0, 32'h0,  5'd1};
    tbl[1] = '{1, 1, 32'hA1, 0, 0, 0, 32'h0,  5'd2};
    tbl[2] = '{1, 1, 32'hA2, 0, 0, 0, 32'h0,  5'd3};
    tbl[3] = '{1, 1, 32'hA3, 0, 0, 0, 32'h0,  5'd4};
    tbl[4] = '{0, 0, 32'h0,  1, 1, 1, 32'hA0, 5'd3};
    tbl[5] = '{0, 0, 32'h0,  1, 1, 1, 32'hA1, 5'd2};
    tbl[6] = '{0, 0, 32'h0,  1, 1, 1, 32'hA2, 5'd1};
    tbl[7] = '{0, 0, 32'h0,  1, 1, 1, 32'hA3, 5'd0};

    rst = 0; flush = 0; wr = 0; wr_ch = 0; di = 0; rd = 0; rd_ch = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1;
    cyc(0, 0, 0, 0, 0, 0);

    // ch1 basic push/pop table
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].w, tbl[i].wc, tbl[i].d, tbl[i].r, tbl[i].rc, 0);
      chk("tbl_v", i, 32'(dout_v), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk("tbl_dout", i, dout, tbl[i].dout);
        chk("tbl_ch", i, 32'(dout_ch), 32'd1);
      end
      chk("tbl_cnt1", i, 32'(cnt[1]), 32'(tbl[i].c1));
      chk("tbl_empty1", i, 32'(empty[1]), 32'(tbl[i].c1 == 0));
    end

    // ch2 fill, almost_full threshold, dropped 17th write
    for (int i = 0; i < DEP; i++) begin
      cyc(1, 2, 32'hB00 + i, 0, 0, 0);
      if (i == 10) chk("af_at11", 2, 32'(almost_full[2]), 32'd0);
      if (i == 11) chk("af_at12", 2, 32'(almost_full[2]), 32'd1);
    end
    chk("full2", 2, 32'(full[2]), 32'd1);
    cyc(1, 2, 32'hBFF, 0, 0, 0);
    chk("cnt2_drop", 2, 32'(cnt[2]), 32'd16);
`ifdef RFPHOENIX_MCFIFO_ERR_EN
    chk("ovf2", 2, 32'(ovf[2]), 32'd1);
`endif
    cyc(0, 0, 0, 1, 2, 0);
    chk("pop2_first", 2, dout, 32'hB00);
    for (int i = 1; i < DEP; i++) cyc(0, 0, 0, 1, 2, 0);
    chk("pop2_last", 2, dout, 32'hB0F);
    cyc(0, 0, 0, 1, 2, 0);
    chk("empty_rd_v", 2, 32'(dout_v), 32'd0);
    chk("empty_rd_hold", 2, dout, 32'hB0F);
    cyc(0, 0, 0, 0, 0, 4'b0100);

    // ch0 bypass
    cyc(1, 0, 32'h55, 1, 0, 0);
    chk("byp_dout", 0, dout, 32'h55);
    chk("byp_v", 0, 32'(dout_v), 32'd1);
    chk("byp_cnt", 0, 32'(cnt[0]), 32'd0);

    // ch3 full with simultaneous rd & wr
    for (int i = 0; i < DEP; i++) cyc(1, 3, 32'hC00 + i, 0, 0, 0);
    cyc(1, 3, 32'hCAA, 1, 3, 0);
    chk("full_rw_dout", 3, dout, 32'hC00);
    chk("full_rw_cnt", 3, 32'(cnt[3]), 32'd16);
    for (int i = 0; i < DEP; i++) cyc(0, 0, 0, 1, 3, 0);
    chk("full_rw_last", 3, dout, 32'hCAA);

    // flush priority over rd/wr on ch0; ch1 untouched
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'hD0 + i, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'hE0 + i, 0, 0, 0);
    cyc(1, 0, 32'hEE, 1, 0, 4'b0001);
    chk("flush_cnt0", 0, 32'(cnt[0]), 32'd0);
    chk("flush_v", 0, 32'(dout_v), 32'd0);
    chk("flush_cnt1", 1, 32'(cnt[1]), 32'd3);
    cyc(0, 0, 0, 1, 1, 0);
    chk("post_flush1", 1, dout, 32'hD0);

    // random traffic, biased to ch1 to force pointer wrap
    for (int i = 0; i < 600; i++) begin
      bit w, r;
      bit [1:0] wc, rc;
      bit [3:0] fl;
      w  = ($urandom % 3) != 0;
      r  = ($urandom % 3) != 0;
      wc = ($urandom % 2) ? 2'd1 : 2'($urandom % 4);
      rc = ($urandom % 2) ? 2'd1 : 2'($urandom % 4);
      fl = ($urandom % 40 == 0) ? 4'(1 << ($urandom % 4)) : 4'd0;
      cyc(w, wc, $urandom, r, rc, fl);
    end

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'hF0 + i, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    #2;
    rst = 0;
    #1;
    model_reset();
    chk("rst_v", 0, 32'(dout_v), 32'd0);
    chk("rst_empty", 0, 32'(empty), 32'hF);
    check_all();
    @(posedge clk);
    #1;
    rst = 1;
    cyc(1, 1, 32'h77, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("rst_after", 1, dout, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
